// File: rtl/d2b_converter_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding, digit constants and the binary-width helper.
package d2b_defs;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } d2b_state_t;

   localparam int NIB_W   = 4;
   localparam int BCD_MAX = 9;
   localparam int SUB_TH  = 8;
   localparam int SUB_ADJ = 3;

   // Bits needed to hold 10**digits - 1, i.e. $clog2(10**digits).
   function automatic int calc_bin_w(input int digits);
      longint v;
      int     w;
      v = 1;
      for (int i = 0; i < digits; i++) begin
         v = v * 10;
      end
      w = 0;
      while ((longint'(1) << w) < v) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/d2b_converter_seq_step.sv
// One reverse double dabble iteration over {bcd field, binary field}.
// Ports: i_vec current shift register, o_vec shifted and corrected value.
module d2b_step
   import d2b_defs::*;
#(
   parameter  int DIGITS = 2,
   parameter  int BIN_W  = 7,
   localparam int W      = DIGITS * NIB_W + BIN_W
)(
   input  logic [W-1:0] i_vec,
   output logic [W-1:0] o_vec
);

   logic [W-1:0] w_sh;

   assign w_sh = i_vec >> 1;

   // After the shift a BCD digit holding >= 8 carried in a half-ten
   // from the digit above; taking 3 off restores a valid digit.
   always_comb begin
      o_vec = w_sh;
      for (int d = 0; d < DIGITS; d++) begin
         if (w_sh[BIN_W + NIB_W*d +: NIB_W] >= NIB_W'(SUB_TH)) begin
            o_vec[BIN_W + NIB_W*d +: NIB_W] =
               w_sh[BIN_W + NIB_W*d +: NIB_W] - NIB_W'(SUB_ADJ);
         end
      end
   end

endmodule

// File: rtl/d2b_converter_seq.sv
// Multi-cycle BCD-to-binary converter, one shift/correct step per clock,
// valid/ready on input and output. Optional macro: D2B_RANGE_CHECK_EN.
// Ports: clk, sys_rst_n (async low); in_valid/in_ready/bcd_in accept side;
// out_valid/out_ready/bin_out/bcd_err/range_err result side.
module d2b_converter_seq
   import d2b_defs::*;
#(
   parameter  int DEC_DIGITS = 2,
   parameter  int Max        = 99,
   parameter  int Min        = 0,
   localparam int N          = DEC_DIGITS * NIB_W,
   localparam int BIN_W      = calc_bin_w(DEC_DIGITS),
   localparam int CNT_W      = $clog2(BIN_W + 1)
)(
   input  logic             clk,
   input  logic             sys_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     bcd_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BIN_W-1:0] bin_out,
   output logic             bcd_err,
   output logic             range_err
);

   localparam int SR_W = N + BIN_W;

   if (Max < Min) begin : g_bad_range
      $error("d2b_converter_seq: Max below Min");
   end

   d2b_state_t       r_state;
   d2b_state_t       w_next_state;
   logic [SR_W-1:0]  r_shift;
   logic [SR_W-1:0]  w_step;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bad;
   logic [BIN_W-1:0] r_bin;
   logic             r_bcd_err;
   logic             r_range_err;
   logic             w_bad;
   logic             w_last;
   logic             w_range;
   logic [BIN_W-1:0] w_res;

   d2b_step #(
      .DIGITS (DEC_DIGITS),
      .BIN_W  (BIN_W)
   ) u_step (
      .i_vec (r_shift),
      .o_vec (w_step)
   );

   always_comb begin
      w_bad = 1'b0;
      for (int d = 0; d < DEC_DIGITS; d++) begin
         if (bcd_in[NIB_W*d +: NIB_W] > NIB_W'(BCD_MAX)) begin
            w_bad = 1'b1;
         end
      end
   end

   assign w_last = (r_cnt == CNT_W'(BIN_W));
   assign w_res  = r_shift[BIN_W-1:0];

`ifdef D2B_RANGE_CHECK_EN
   assign w_range = (int'(w_res) > Max) || (int'(w_res) < Min);
`else
   assign w_range = 1'b0;
`endif

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A bad digit still passes through CONV for one cycle (no
   // iterations) so the result appears one edge after accept.
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_next_state = S_CONV;
            end
         end
         S_CONV: begin
            if (r_bad || w_last) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_shift     <= '0;
         r_cnt       <= '0;
         r_bad       <= 1'b0;
         r_bin       <= '0;
         r_bcd_err   <= 1'b0;
         r_range_err <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_shift <= {bcd_in, {BIN_W{1'b0}}};
                  r_cnt   <= '0;
                  r_bad   <= w_bad;
               end
            end
            S_CONV: begin
               if (r_bad) begin
                  r_bin       <= '0;
                  r_bcd_err   <= 1'b1;
                  r_range_err <= 1'b0;
               end else if (w_last) begin
                  assert (r_shift[SR_W-1:BIN_W] == '0);
                  r_bin       <= w_res;
                  r_bcd_err   <= 1'b0;
                  r_range_err <= w_range;
               end else begin
                  r_shift <= w_step;
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_bcd_err   <= 1'b0;
                  r_range_err <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bin_out   = r_bin;
   assign bcd_err   = r_bcd_err;
   assign range_err = r_range_err;

endmodule

// File: tb/tb_d2b_converter_seq.sv
// Self-checking bench for d2b_converter_seq: directed cases, a full
// 00..99 sweep and random codes against a decimal arithmetic model.
module tb_d2b_converter_seq;

   localparam int DIG  = 2;
   localparam int BW   = $clog2(10**DIG);
   localparam int MAXV = 59;
   localparam int MINV = 0;

   logic          clk;
   logic          sys_rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    bcd_in;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] bin_out;
   logic          bcd_err;
   logic          range_err;

   int errors;
   int checks;

   d2b_converter_seq #(
      .DEC_DIGITS (DIG),
      .Max        (MAXV),
      .Min        (MINV)
   ) dut (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd_in    (bcd_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bin_out   (bin_out),
      .bcd_err   (bcd_err),
      .range_err (range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: decimal value of the code, and whether any digit is >9.
   function automatic logic is_bad(input logic [7:0] b);
      return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
   endfunction

   function automatic int dec_val(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic exp_range(input int v);
`ifdef D2B_RANGE_CHECK_EN
      return (v > MAXV) || (v < MINV);
`else
      return 1'b0;
`endif
   endfunction

   // Issue one request, measure latency, optionally stall the consumer.
   task automatic send(input logic [7:0] v, input int hold,
                       input string tag);
      int   k;
      int   lat;
      logic busy_rdy;
      logic stable;
      int   e_bin;
      logic e_err;
      logic e_rng;
      e_err = is_bad(v);
      e_bin = e_err ? 0 : dec_val(v);
      e_rng = e_err ? 1'b0 : exp_range(e_bin);
      out_ready = (hold == 0);
      k = 0;
      while (!in_ready && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk({tag, " ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      bcd_in   = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      bcd_in   = 8'($urandom);
      lat      = 0;
      busy_rdy = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_rdy = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), e_err ? 32'd1 : 32'(BW + 1));
      chk({tag, " busy"}, 32'(busy_rdy), 32'd0);
      chk({tag, " bin"}, 32'(bin_out), 32'(e_bin));
      chk({tag, " bcd_err"}, 32'(bcd_err), 32'(e_err));
      chk({tag, " range_err"}, 32'(range_err), 32'(e_rng));
      if (hold > 0) begin
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || bin_out !== BW'(e_bin) ||
                bcd_err !== e_err || range_err !== e_rng)
               stable = 1'b0;
         end
         chk({tag, " hold"}, 32'(stable), 32'd1);
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " drop"}, 32'(out_valid), 32'd0);
      chk({tag, " idle"}, 32'(in_ready), 32'd1);
      chk({tag, " clr"}, 32'({bcd_err, range_err}), 32'd0);
   endtask

   initial begin
      logic [7:0] v;
      logic       seen;
      errors    = 0;
      checks    = 0;
      sys_rst_n = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      bcd_in    = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst bin", 32'(bin_out), 32'd0);
      chk("rst errs", 32'({bcd_err, range_err}), 32'd0);
      @(negedge clk);
      sys_rst_n = 1'b1;
      @(posedge clk); #1;

      send(8'h42, 0, "d42");
      send(8'h3A, 0, "bad3A");
      send(8'h57, 5, "hold57");

      for (int i = 0; i < 100; i++) begin
         v = 8'(((i / 10) << 4) | (i % 10));
         send(v, 0, "sweep");
      end

      // Abort 0x99 at iteration 3.
      in_valid = 1'b1;
      bcd_in   = 8'h99;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      sys_rst_n = 1'b0;
      #1;
      chk("abort in_ready", 32'(in_ready), 32'd1);
      chk("abort out_valid", 32'(out_valid), 32'd0);
      chk("abort bin", 32'(bin_out), 32'd0);
      chk("abort errs", 32'({bcd_err, range_err}), 32'd0);
      @(negedge clk);
      sys_rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort no output", 32'(seen), 32'd0);
      send(8'h15, 0, "after15");

      send(8'h75, 0, "rng75");
      send(8'h59, 0, "rng59");
      send(8'h60, 2, "rng60");

      for (int i = 0; i < 40; i++) begin
         send(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)),
              "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
